// File: rtl/render_frame_scheduler_pkg.sv
// Shared types for the render frame scheduler: bin/level vector types,
// scheduler state encoding and a saturating 4-bit subtract helper.
package render_pkg;
  localparam int N_BINS = 16;

  typedef logic [N_BINS-1:0][15:0] bins_t;
  typedef logic [N_BINS-1:0][3:0]  levels_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_HOLD,
    S_COMMIT
  } sched_state_t;

  // a - b, floored at 0 instead of wrapping
  function automatic logic [3:0] sub_sat0(input logic [3:0] a, input logic [3:0] b);
    return (a > b) ? 4'(a - b) : 4'd0;
  endfunction
endpackage

// File: rtl/render_frame_scheduler_if.sv
// Frame hand-off bus between FFT core, scheduler and renderers.
//  fft_valid/fft_data/fft_ready : frame offer from the FFT core
//  levels/levels_valid          : committed log2 levels to the renderers
// master = FFT/render side, slave = scheduler.
interface render_frame_scheduler_if;
  import render_pkg::*;

  logic    fft_valid;
  bins_t   fft_data;
  logic    fft_ready;
  levels_t levels;
  logic    levels_valid;

  modport master (output fft_valid, fft_data, input fft_ready, levels, levels_valid);
  modport slave  (input fft_valid, fft_data, output fft_ready, levels, levels_valid);
endinterface

// File: rtl/render_frame_scheduler_log2_u16.sv
// Combinational floor(log2(x)) for a 16-bit unsigned value.
//  x     : input magnitude
//  level : index of the most significant set bit; 0 when x is 0 or 1
module log2_u16 (
  input  logic [15:0] x,
  output logic [3:0]  level
);
  always_comb begin
    level = '0;
    for (int i = 1; i < 16; i++)
      if (x[i]) level = 4'(i);
  end
endmodule

// File: rtl/render_frame_scheduler.sv
// Render frame scheduler: accepts one FFT frame, converts its 16 bins to
// 4-bit log2 levels one per cycle through a shared converter, applies
// peak-hold decay and commits the level vector only during VGA blanking.
//  i_clk, i_rst : clock, asynchronous active-high reset
//  fft          : frame handshake in, committed levels + 1-cycle valid out
//  i_vga_lock   : 1 = active video, 0 = blanking (asynchronous to i_clk)
//  o_busy       : scheduler not idle
//  o_drop_cnt   : frames offered while not ready, saturating at 255
module render_frame_scheduler
  import render_pkg::*;
#(
  parameter int DECAY       = 1,
  parameter int HOLD_EN     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  render_frame_scheduler_if.slave  fft,
  input  logic                     i_vga_lock,
  output logic                     o_busy,
  output logic [7:0]               o_drop_cnt
);
  sched_state_t state, state_nxt;
  logic [3:0]   k;
  bins_t        bins_q;
  levels_t      new_q;
  levels_t      held_q;
  levels_t      held_nxt;
  logic         lv_vld_q;
  logic [3:0]   cur_lvl;
  logic [SYNC_STAGES-1:0] sync_q;
  logic         lock_s;

  assign lock_s           = sync_q[SYNC_STAGES-1];
  assign fft.fft_ready    = (state == S_IDLE);
  assign fft.levels       = held_q;
  assign fft.levels_valid = lv_vld_q;
  assign o_busy           = (state != S_IDLE);

  log2_u16 u_log2 (.x(bins_q[k]), .level(cur_lvl));

  // Resets to 1 so a fresh reset is treated as active video.
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) sync_q <= '1;
    else       sync_q <= (sync_q << 1) | SYNC_STAGES'(i_vga_lock);

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fft.fft_valid) state_nxt = S_CONV;
      S_CONV:   if (k == 4'd15)    state_nxt = S_HOLD;
      S_HOLD:   if (!lock_s)       state_nxt = S_COMMIT;
      S_COMMIT:                    state_nxt = S_IDLE;
      default:                     state_nxt = S_IDLE;
    endcase
  end

  // Per-bin commit value: new level, or the decayed peak if that is higher.
  always_comb begin
    held_nxt = new_q;
    if (HOLD_EN != 0)
      for (int b = 0; b < N_BINS; b++) begin
        logic [3:0] dec;
        dec = sub_sat0(held_q[b], 4'(DECAY));
        held_nxt[b] = (new_q[b] > dec) ? new_q[b] : dec;
      end
  end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      bins_q   <= '0;
      new_q    <= '0;
      held_q   <= '0;
      k        <= '0;
      lv_vld_q <= 1'b0;
    end else begin
      lv_vld_q <= 1'b0;
      case (state)
        S_IDLE:
          if (fft.fft_valid) begin
            bins_q <= fft.fft_data;
            k      <= '0;
          end
        S_CONV: begin
          new_q[k] <= cur_lvl;
          k        <= k + 4'd1;
        end
        S_COMMIT: begin
          held_q   <= held_nxt;
          lv_vld_q <= 1'b1;
        end
        default: ;
      endcase
    end

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)
      o_drop_cnt <= '0;
    else if (fft.fft_valid && !fft.fft_ready && o_drop_cnt != 8'hFF)
      o_drop_cnt <= o_drop_cnt + 8'd1;
endmodule

// File: tb/tb_render_frame_scheduler.sv
// Self-checking bench for render_frame_scheduler: directed scenarios plus
// randomized frames, checked against a peak-hold model built from plain
// integer log2 and max/decay arithmetic.
module tb_render_frame_scheduler;
  import render_pkg::*;

  localparam int SYNC_STAGES = 2;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       vga_lock;
  logic       busy;
  logic [7:0] drop;

  always #5 i_clk = ~i_clk;

  render_frame_scheduler_if bus();

  render_frame_scheduler #(.DECAY(1), .HOLD_EN(1), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .fft        (bus.slave),
    .i_vga_lock (vga_lock),
    .o_busy     (busy),
    .o_drop_cnt (drop)
  );

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int m_held [N_BINS];

  always @(negedge i_clk) if (bus.levels_valid === 1'b1) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lvl(input int x);
    int l = 0;
    while (x > 1) begin x = x / 2; l++; end
    return l;
  endfunction

  task automatic model_commit(input bins_t b);
    for (int i = 0; i < N_BINS; i++) begin
      int nl, dec;
      nl  = ref_lvl(int'(b[i]));
      dec = (m_held[i] > 1) ? m_held[i] - 1 : 0;
      m_held[i] = (nl > dec) ? nl : dec;
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [63:0] v;
    for (int i = 0; i < N_BINS; i++) v[i*4 +: 4] = 4'(m_held[i]);
    return v;
  endfunction

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int i = 0; i < N_BINS; i++) m_held[i] = 0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  // Offer a frame while idle and check the commit with blanking present:
  // the valid pulse is sampled 18 edges after the accept edge.
  task automatic send_and_check(input bins_t b, input string tag);
    int n, p0;
    bit got;
    @(negedge i_clk);
    chk({tag, "_ready"}, 64'(bus.fft_ready), 64'd1);
    bus.fft_valid = 1'b1;
    bus.fft_data  = b;
    @(posedge i_clk);
    #1 bus.fft_valid = 1'b0;
    p0 = pulses;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    model_commit(b);
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge i_clk); #1;
      n++;
      if (bus.levels_valid === 1'b1) got = 1;
    end
    chk({tag, "_lat"}, 64'(n), 64'd18);
    chk({tag, "_lv"}, 64'(bus.levels), model_vec());
    @(posedge i_clk); #1;
    chk({tag, "_pulse1"}, 64'(bus.levels_valid), 64'd0);
    chk({tag, "_npulse"}, 64'(pulses - p0), 64'd1);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin : main
    bins_t b;
    bins_t q[$];
    int n, p0, drops;
    bit got;
    logic [63:0] lv0;

    i_rst = 1'b1;
    vga_lock = 1'b0;
    bus.fft_valid = 1'b0;
    bus.fft_data = '0;
    for (int i = 0; i < N_BINS; i++) m_held[i] = 0;
    #12;
    chk("rst_levels", 64'(bus.levels), 64'd0);
    chk("rst_valid", 64'(bus.levels_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("rst_ready", 64'(bus.fft_ready), 64'd1);

    // 1: one-hot ramp -> level k at bin k
    for (int i = 0; i < N_BINS; i++) b[i] = 16'(1 << i);
    send_and_check(b, "ramp");
    chk("ramp_const", 64'(bus.levels), 64'hFEDCBA9876543210);

    // 2: single full-scale bin
    do_reset();
    b = '0; b[7] = 16'hFFFF;
    send_and_check(b, "bin7");
    chk("bin7_const", 64'(bus.levels), 64'h0000_0000_F000_0000);

    // 3: peak hold decays by one per frame down to the floor
    do_reset();
    for (int i = 0; i < N_BINS; i++) b[i] = 16'h8000;
    send_and_check(b, "peak");
    for (int f = 1; f <= 16; f++) begin
      send_and_check('0, "decay");
      chk("decay_bin0", 64'(bus.levels[0]), 64'((f > 15) ? 0 : 15 - f));
    end
    chk("decay_floor", 64'(bus.levels), 64'd0);

    // randomized frames on top of whatever peaks remain
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < N_BINS; i++) b[i] = 16'($urandom) >> $urandom_range(0, 16);
      send_and_check(b, "rand");
    end

    // 4: long active video holds the commit off
    @(negedge i_clk);
    vga_lock = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge i_clk);
    for (int i = 0; i < N_BINS; i++) b[i] = 16'($urandom);
    bus.fft_valid = 1'b1;
    bus.fft_data = b;
    @(posedge i_clk);
    #1 bus.fft_valid = 1'b0;
    lv0 = bus.levels;
    p0 = pulses;
    model_commit(b);
    repeat (200) @(posedge i_clk);
    #1;
    chk("lock_levels", 64'(bus.levels), lv0);
    chk("lock_nopulse", 64'(pulses - p0), 64'd0);
    chk("lock_busy", 64'(busy), 64'd1);
    @(negedge i_clk);
    vga_lock = 1'b0;
    n = 0; got = 0;
    while (n < 40 && !got) begin
      @(posedge i_clk); #1;
      n++;
      if (bus.levels_valid === 1'b1) got = 1;
    end
    chk("lock_lat", 64'(n), 64'(SYNC_STAGES + 2));
    chk("lock_lv", 64'(bus.levels), model_vec());
    repeat (20) @(posedge i_clk);
    #1 chk("lock_npulse", 64'(pulses - p0), 64'd1);
    chk("lock_drop", 64'(drop), 64'd0);

    // 5: valid held high with changing data; offers while busy are dropped
    drops = 0;
    p0 = pulses;
    for (int c = 0; c < 300; c++) begin
      @(negedge i_clk);
      for (int i = 0; i < N_BINS; i++) b[i] = 16'($urandom) >> $urandom_range(0, 16);
      bus.fft_valid = 1'b1;
      bus.fft_data = b;
      if (bus.fft_ready === 1'b1) q.push_back(b);
      else drops++;
    end
    @(negedge i_clk);
    bus.fft_valid = 1'b0;
    n = 0;
    while (n < 100 && busy !== 1'b0) begin @(negedge i_clk); n++; end
    chk("drop_drain", 64'(busy), 64'd0);
    repeat (3) @(negedge i_clk);
    chk("drop_commits", 64'(pulses - p0), 64'(q.size()));
    while (q.size() > 0) model_commit(q.pop_front());
    chk("drop_lv", 64'(bus.levels), model_vec());
    chk("drop_cnt", 64'(drop), 64'((drops > 255) ? 255 : drops));

    // 6: reset in the middle of conversion discards the frame
    @(negedge i_clk);
    for (int i = 0; i < N_BINS; i++) b[i] = 16'hFFFF;
    bus.fft_valid = 1'b1;
    bus.fft_data = b;
    @(posedge i_clk);
    #1 bus.fft_valid = 1'b0;
    repeat (8) @(posedge i_clk);
    #1 i_rst = 1'b1;
    for (int i = 0; i < N_BINS; i++) m_held[i] = 0;
    #1;
    chk("mid_levels", 64'(bus.levels), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_drop", 64'(drop), 64'd0);
    p0 = pulses;
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("mid_nopulse", 64'(pulses - p0), 64'd0);
    chk("mid_ready", 64'(bus.fft_ready), 64'd1);
    chk("mid_levels2", 64'(bus.levels), 64'd0);
    for (int i = 0; i < N_BINS; i++) b[i] = 16'($urandom);
    send_and_check(b, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
